// File: rtl/parking_access_ctrl.sv
// Parking-lot access controller: occupancy counting, password-gated entry,
// retry lockout and timed gate control with fully registered outputs.
module parking_access_ctrl #(
    parameter int unsigned CAPACITY       = 8,
    parameter int unsigned PW_LEN         = 4,
    parameter int unsigned PW_DIGIT_W     = 3,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned GATE_CYCLES    = 100000000,
    parameter int unsigned LOCKOUT_CYCLES = 500000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enter_req,
    input  logic                           exit_req,
    input  logic                           pw_valid,
    input  logic [PW_DIGIT_W-1:0]          pw_digit,
    input  logic [PW_LEN*PW_DIGIT_W-1:0]   pw_key,
    output logic [$clog2(CAPACITY+1)-1:0]  count,
    output logic                           full,
    output logic                           empty,
    output logic                           gate_open,
    output logic                           pw_prompt,
    output logic                           pw_fail,
    output logic                           reject,
    output logic                           locked,
    output logic [2:0]                     state
);

    localparam int unsigned CW   = $clog2(CAPACITY + 1);
    localparam int unsigned IW   = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;
    localparam int unsigned TRW  = $clog2(MAX_TRIES + 1);
    localparam int unsigned TM1  = (GATE_CYCLES > LOCKOUT_CYCLES) ? GATE_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMAX = (TM1 > TIMEOUT_CYCLES) ? TM1 : TIMEOUT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPwEntry = 3'd1,
        StGateIn  = 3'd2,
        StGateOut = 3'd3,
        StLockout = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    mismatch_q, mismatch_d;
    logic [TRW-1:0]          tries_q, tries_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    reject_q, reject_d;
    logic                    pw_fail_q, pw_fail_d;
    logic                    full_q, empty_q, gate_q, prompt_q, locked_q;
    logic [PW_DIGIT_W-1:0]   key_digit;
    logic                    bad_so_far;

    always_comb begin
        key_digit = '0;
        for (int i = 0; i < PW_LEN; i++) begin
            if (idx_q == IW'(i)) key_digit = pw_key[i*PW_DIGIT_W +: PW_DIGIT_W];
        end
    end

    // Sticky mismatch including the digit being strobed this cycle.
    assign bad_so_far = mismatch_q | (pw_digit != key_digit);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        tries_d    = tries_q;
        timer_d    = timer_q;
        reject_d   = 1'b0;
        pw_fail_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (exit_req) begin
                    if (count_q != '0) begin
                        state_d = StGateOut;
                        count_d = count_q - CW'(1);
                        timer_d = '0;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (enter_req) begin
                    if (count_q != CW'(CAPACITY)) begin
                        state_d    = StPwEntry;
                        idx_d      = '0;
                        mismatch_d = 1'b0;
                        timer_d    = '0;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            StPwEntry: begin
                if (pw_valid) begin
                    timer_d    = '0;
                    mismatch_d = bad_so_far;
                    idx_d      = idx_q + IW'(1);
                    if (idx_q == IW'(PW_LEN - 1)) begin
                        if (!bad_so_far) begin
                            state_d = StGateIn;
                            count_d = count_q + CW'(1);
                            tries_d = '0;
                        end else begin
                            pw_fail_d = 1'b1;
                            tries_d   = tries_q + TRW'(1);
                            state_d   = (tries_d == TRW'(MAX_TRIES)) ? StLockout : StIdle;
                        end
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StGateIn, StGateOut: begin
                if (timer_q == TW'(GATE_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StLockout: begin
                if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
                    state_d = StIdle;
                    tries_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
            tries_q    <= '0;
            timer_q    <= '0;
            reject_q   <= 1'b0;
            pw_fail_q  <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            gate_q     <= 1'b0;
            prompt_q   <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            mismatch_q <= mismatch_d;
            tries_q    <= tries_d;
            timer_q    <= timer_d;
            reject_q   <= reject_d;
            pw_fail_q  <= pw_fail_d;
            full_q     <= (count_d == CW'(CAPACITY));
            empty_q    <= (count_d == '0);
            gate_q     <= (state_d == StGateIn) || (state_d == StGateOut);
            prompt_q   <= (state_d == StPwEntry);
            locked_q   <= (state_d == StLockout);
        end
    end

    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign gate_open = gate_q;
    assign pw_prompt = prompt_q;
    assign pw_fail   = pw_fail_q;
    assign reject    = reject_q;
    assign locked    = locked_q;
    assign state     = state_q;

endmodule
